// File: rtl/nf_run_pkg.sv
// Shared run-control types: sequencer states and debugger command opcodes.
// Used by nf_run_ctrl, its sub-module, nf_top and the bench.
package nf_run_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_HALT = 2'd2,
    CMD_STEP = 2'd3
  } run_cmd_t;

endpackage

// File: rtl/nf_bp_match.sv
// Single address breakpoint: registered enable/address, word-granular compare,
// suppressed while the skip flag lets the breakpointed instruction through.
module nf_bp_match
  import nf_run_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] instr_addr,
  input  logic        skip,
  output logic        bp_match
);

  logic        bp_en_q, bp_en_d;
  logic [29:0] bp_word_q, bp_word_d;
  logic        unused_lsbs;

  always_comb begin
    bp_en_d   = bp_en;
    bp_word_d = bp_addr[31:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_en_q   <= 1'b0;
      bp_word_q <= '0;
    end else begin
      bp_en_q   <= bp_en_d;
      bp_word_q <= bp_word_d;
    end
  end

  // Byte offset within the word never participates in the compare.
  assign unused_lsbs = ^{bp_addr[1:0], instr_addr[1:0]};

  assign bp_match = bp_en_q & (instr_addr[31:2] == bp_word_q) & ~skip;

endmodule

// File: rtl/nf_run_ctrl.sv
// Run-control sequencer: gates the divider strobe into cpu_en under a
// HALT/RUN/STEP/BREAK state machine with step count, breakpoint and retire count.
module nf_run_ctrl
  import nf_run_pkg::*;
#(
  parameter bit RESET_RUN = 1'b1,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_en,
  input  logic [31:0]       instr_addr,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              cmd_ready,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic              cmd_err,
  output logic [STEP_W-1:0] steps_left,
  output logic [31:0]       retired
);

  localparam run_state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

  run_state_t        state_q, state_d;
  logic [STEP_W-1:0] steps_left_q, steps_left_d;
  logic [31:0]       retired_q, retired_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic              cmd_err_q, cmd_err_d;
  logic              bp_match;
  logic              running;
  logic              idle;
  run_cmd_t          cmd;

  nf_bp_match u_bp_match (
    .clk        (clk),
    .reset      (reset),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .instr_addr (instr_addr),
    .skip       (skip_q),
    .bp_match   (bp_match)
  );

  assign running   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign idle      = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign cmd       = run_cmd_t'(cmd_op);
  assign cmd_ready = ~reset;
  // Registered state and div_en only: the command path never reaches cpu_en.
  assign cpu_en    = ~reset & div_en & running & ~bp_match;

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    retired_d    = retired_q;
    skip_d       = skip_q;
    bp_hit_d     = 1'b0;
    cmd_err_d    = 1'b0;

    if (cpu_en) begin
      retired_d = retired_q + 32'd1;
      skip_d    = 1'b0;
      if (state_q == ST_STEP && steps_left_q != '0) begin
        steps_left_d = steps_left_q - 1'b1;
        if (steps_left_q == STEP_W'(1)) state_d = ST_HALT;
      end
    end else if (div_en && running && bp_match) begin
      state_d  = ST_BREAK;
      bp_hit_d = 1'b1;
    end

    // Commands take priority over strobe-driven transitions.
    if (cmd_valid) begin
      unique case (cmd)
        CMD_HALT: begin
          state_d      = ST_HALT;
          steps_left_d = '0;
          skip_d       = 1'b0;
          bp_hit_d     = 1'b0;
        end
        CMD_RUN: begin
          if (idle) begin
            state_d = ST_RUN;
            skip_d  = (state_q == ST_BREAK);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_STEP: begin
          if (idle) begin
            state_d      = ST_STEP;
            steps_left_d = (cmd_steps == '0) ? STEP_W'(1) : cmd_steps;
            skip_d       = (state_q == ST_BREAK);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      steps_left_q <= '0;
      retired_q    <= '0;
      skip_q       <= 1'b0;
      bp_hit_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      retired_q    <= retired_d;
      skip_q       <= skip_d;
      bp_hit_q     <= bp_hit_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign state      = state_q;
  assign steps_left = steps_left_q;
  assign retired    = retired_q;
  assign bp_hit     = bp_hit_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_nf_run_ctrl.sv
// Directed bench for nf_run_ctrl: reset, free run, stepping, breakpoint,
// command/strobe collisions, illegal commands and mid-step reset.
module tb_nf_run_ctrl;
  import nf_run_pkg::*;

  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              div_en;
  logic [31:0]       instr_addr;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_ready;
  logic              bp_en;
  logic [31:0]       bp_addr;
  logic              cpu_en;
  logic [1:0]        state;
  logic              bp_hit;
  logic              cmd_err;
  logic [STEP_W-1:0] steps_left;
  logic [31:0]       retired;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;

  always #5 clk = ~clk;

  nf_run_ctrl #(.RESET_RUN(1'b1), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_en     (div_en),
    .instr_addr (instr_addr),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_steps  (cmd_steps),
    .cmd_ready  (cmd_ready),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cpu_en     (cpu_en),
    .state      (state),
    .bp_hit     (bp_hit),
    .cmd_err    (cmd_err),
    .steps_left (steps_left),
    .retired    (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input run_cmd_t op, input logic [STEP_W-1:0] n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = n;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = CMD_NOP;
  endtask

  initial begin
    reset = 1'b1; div_en = 1'b0; instr_addr = 32'h0; cmd_valid = 1'b0;
    cmd_op = CMD_NOP; cmd_steps = '0; bp_en = 1'b0; bp_addr = 32'h0;
    tick(); tick();
    div_en = 1'b1; #1;
    check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    div_en = 1'b0;
    reset  = 1'b0;
    tick();
    check("reset_state", {30'd0, state}, 32'(ST_RUN));
    check("reset_retired", retired, 32'd0);
    check("reset_steps", {24'd0, steps_left}, 32'd0);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Free run: cpu_en mirrors div_en, strobes on cycles 0,4,8,12,16
    for (int i = 0; i < 20; i++) begin
      div_en = (i % 4 == 0); #1;
      if (i < 5) check("run_mirror", {31'd0, cpu_en}, {31'd0, div_en});
      tick();
    end
    div_en = 1'b0;
    check("run_retired", retired, 32'd5);
    check("run_state", {30'd0, state}, 32'(ST_RUN));

    // Halt, then step 3 with a strobe every other cycle
    send(CMD_HALT, '0);
    check("halt_state", {30'd0, state}, 32'(ST_HALT));
    send(CMD_STEP, 8'd3);
    check("step_state", {30'd0, state}, 32'(ST_STEP));
    check("step_loaded", {24'd0, steps_left}, 32'd3);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      div_en = (i % 2 == 0); #1;
      if (cpu_en) pulses++;
      tick();
    end
    div_en = 1'b0;
    check("step_pulses", pulses, 32'd3);
    check("step_done_steps", {24'd0, steps_left}, 32'd0);
    check("step_done_state", {30'd0, state}, 32'(ST_HALT));
    check("step_retired", retired, 32'd8);

    // Breakpoint at 0x40; 0x42 is in the same word
    bp_en = 1'b1; bp_addr = 32'h40; instr_addr = 32'h38;
    tick();
    send(CMD_RUN, '0);
    check("bp_run_state", {30'd0, state}, 32'(ST_RUN));
    div_en = 1'b1; #1;
    check("bp_pre_strobe", {31'd0, cpu_en}, 32'd1);
    tick();
    div_en = 1'b0; instr_addr = 32'h42;
    tick();
    check("bp_noen_state", {30'd0, state}, 32'(ST_RUN));
    check("bp_noen_hit", {31'd0, bp_hit}, 32'd0);
    div_en = 1'b1; #1;
    check("bp_suppress", {31'd0, cpu_en}, 32'd0);
    tick();
    div_en = 1'b0;
    check("bp_state", {30'd0, state}, 32'(ST_BREAK));
    check("bp_hit_pulse", {31'd0, bp_hit}, 32'd1);
    check("bp_retired", retired, 32'd9);
    tick();
    check("bp_hit_clear", {31'd0, bp_hit}, 32'd0);
    send(CMD_RUN, '0);
    check("bp_resume_state", {30'd0, state}, 32'(ST_RUN));
    div_en = 1'b1; #1;
    check("bp_skip_strobe", {31'd0, cpu_en}, 32'd1);
    tick();
    div_en = 1'b0;
    check("bp_skip_state", {30'd0, state}, 32'(ST_RUN));
    check("bp_skip_nohit", {31'd0, bp_hit}, 32'd0);
    check("bp_skip_retired", retired, 32'd10);
    bp_en = 1'b0; instr_addr = 32'h44;
    tick();

    // HALT colliding with a strobe in RUN
    cmd_valid = 1'b1; cmd_op = CMD_HALT; div_en = 1'b1; #1;
    check("halt_coll_strobe", {31'd0, cpu_en}, 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_op = CMD_NOP;
    check("halt_coll_state", {30'd0, state}, 32'(ST_HALT));
    check("halt_coll_retired", retired, 32'd11);
    #1;
    check("halt_blocked", {31'd0, cpu_en}, 32'd0);
    tick();
    div_en = 1'b0;
    check("halt_blk_retired", retired, 32'd11);

    // Illegal STEP while running, then zero-count step
    send(CMD_RUN, '0);
    send(CMD_STEP, 8'd4);
    check("err_pulse", {31'd0, cmd_err}, 32'd1);
    check("err_state", {30'd0, state}, 32'(ST_RUN));
    tick();
    check("err_clear", {31'd0, cmd_err}, 32'd0);
    send(CMD_HALT, '0);
    send(CMD_STEP, 8'd0);
    check("step0_steps", {24'd0, steps_left}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      div_en = 1'b1; #1;
      if (cpu_en) pulses++;
      tick();
    end
    div_en = 1'b0;
    check("step0_pulses", pulses, 32'd1);
    check("step0_state", {30'd0, state}, 32'(ST_HALT));
    check("step0_retired", retired, 32'd12);

    // Reset in the middle of a step sequence
    send(CMD_STEP, 8'd9);
    for (int i = 0; i < 4; i++) begin
      div_en = 1'b1;
      tick();
    end
    check("mid_steps", {24'd0, steps_left}, 32'd5);
    check("mid_retired", retired, 32'd16);
    reset = 1'b1; #1;
    check("mid_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    tick();
    check("mid_rst_state", {30'd0, state}, 32'(ST_RUN));
    check("mid_rst_steps", {24'd0, steps_left}, 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    reset = 1'b0; div_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
